cacheline_ctrl: RTL and testbench



---
 rtl/cacheline_pkg.sv | 36 +++
 rtl/cacheline_stats.sv | 47 ++++
 rtl/cacheline_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_cacheline_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_pkg.sv
// Shared types and constants for the single-line write-back cache controller.
// Optional statistics are enabled with the CACHELINE_CTRL_STATS_EN macro.
package cacheline_pkg;

  localparam int CL_ADDR_W = 8;
  localparam int CL_DATA_W = 32;
  localparam int STATS_W   = 16;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_RESP      = 2'd3
  } state_e;

  // Line layout at the default widths (the controller rebuilds it at its own widths)
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [CL_ADDR_W-1:0] tag;
    logic [CL_DATA_W-1:0] data;
  } line_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    logic [STATS_W-1:0] r;
    if (v == {STATS_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(STATS_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/cacheline_stats.sv
// Saturating hit/miss counter pair, bumped once per accepted request.
// Only instantiated when CACHELINE_CTRL_STATS_EN is defined.
module cacheline_stats
  import cacheline_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               hit_inc,
  input  logic               miss_inc,
  output logic [STATS_W-1:0] hit_count,
  output logic [STATS_W-1:0] miss_count
);

  logic [STATS_W-1:0] hit_q, hit_d;
  logic [STATS_W-1:0] miss_q, miss_d;

  // Next counter values: saturating increment on each event
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_inc) begin
      hit_d = sat_inc(hit_q);
    end else begin
      hit_d = hit_q;
    end
    if (miss_inc) begin
      miss_d = sat_inc(miss_q);
    end else begin
      miss_d = miss_q;
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= {STATS_W{1'b0}};
      miss_q <= {STATS_W{1'b0}};
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: rtl/cacheline_ctrl.sv
// Single-line write-back, write-allocate cache controller.
// Client side: valid/ready request, valid/ready response (hits answered next cycle).
// Memory side: valid/ack initiator; dirty victim is written back before a refill.
// Define CACHELINE_CTRL_STATS_EN to add saturating hit_count/miss_count outputs.
module cacheline_ctrl
  import cacheline_pkg::*;
#(
  parameter int ADDR_W = CL_ADDR_W,
  parameter int DATA_W = CL_DATA_W
) (
`ifdef CACHELINE_CTRL_STATS_EN
  output logic [STATS_W-1:0] hit_count,
  output logic [STATS_W-1:0] miss_count,
`endif
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Line record at this instance's widths
  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } cl_line_t;

  state_e            state_q, state_d;
  cl_line_t          line_q, line_d;
  logic              lat_write_q, lat_write_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_hit_q, resp_hit_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              hit_s;

  // Full address is the tag: one word per line
  assign hit_s = line_q.valid && (line_q.tag == req_addr);

  // Next-state, line update and response capture
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_hit_d   = resp_hit_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          lat_write_d = req_write;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          if (hit_s) begin
            resp_hit_d = 1'b1;
            state_d    = ST_RESP;
            if (req_write) begin
              line_d.data  = req_wdata;
              line_d.dirty = 1'b1;
              resp_rdata_d = req_wdata;
            end else begin
              resp_rdata_d = line_q.data;
            end
          end else if (line_q.valid && line_q.dirty) begin
            state_d = ST_WRITEBACK;
          end else if (req_write) begin
            // Write-allocate straight into a clean or empty line
            line_d.valid = 1'b1;
            line_d.dirty = 1'b1;
            line_d.tag   = req_addr;
            line_d.data  = req_wdata;
            resp_rdata_d = req_wdata;
            resp_hit_d   = 1'b0;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_REFILL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITEBACK: begin
        if (mem_ack) begin
          line_d.dirty = 1'b0;
          if (lat_write_q) begin
            line_d.valid = 1'b1;
            line_d.dirty = 1'b1;
            line_d.tag   = lat_addr_q;
            line_d.data  = lat_wdata_q;
            resp_rdata_d = lat_wdata_q;
            resp_hit_d   = 1'b0;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_REFILL;
          end
        end else begin
          state_d = ST_WRITEBACK;
        end
      end

      ST_REFILL: begin
        if (mem_ack) begin
          line_d.valid = 1'b1;
          line_d.dirty = 1'b0;
          line_d.tag   = lat_addr_q;
          line_d.data  = mem_rdata;
          resp_rdata_d = mem_rdata;
          resp_hit_d   = 1'b0;
          state_d      = ST_RESP;
        end else begin
          state_d = ST_REFILL;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    mem_valid_d  = (state_d == ST_WRITEBACK) || (state_d == ST_REFILL);
    mem_write_d  = (state_d == ST_WRITEBACK);
    mem_addr_d   = {ADDR_W{1'b0}};
    mem_wdata_d  = {DATA_W{1'b0}};
    if (state_d == ST_WRITEBACK) begin
      // Victim stays untouched until acked, so these hold stable
      mem_addr_d  = line_d.tag;
      mem_wdata_d = line_d.data;
    end else if (state_d == ST_REFILL) begin
      mem_addr_d  = lat_addr_d;
      mem_wdata_d = {DATA_W{1'b0}};
    end else begin
      mem_addr_d  = {ADDR_W{1'b0}};
      mem_wdata_d = {DATA_W{1'b0}};
    end
  end

  // State, line and output registers; reset aborts and invalidates the line
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= {ADDR_W{1'b0}};
      lat_wdata_q  <= {DATA_W{1'b0}};
      resp_rdata_q <= {DATA_W{1'b0}};
      resp_hit_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_hit_q   <= resp_hit_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_hit   = resp_hit_q;
  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

`ifdef CACHELINE_CTRL_STATS_EN
  logic accept_s;

  assign accept_s = (state_q == ST_IDLE) && req_valid;

  cacheline_stats u_stats (
    .clock      (clock),
    .reset      (reset),
    .hit_inc    (accept_s && hit_s),
    .miss_inc   (accept_s && !hit_s),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );
`else
  // No statistics in this build
`endif

endmodule

// File: tb/tb_cacheline_ctrl.sv
// Self-checking bench for cacheline_ctrl: directed test-plan scenarios followed by
// randomized requests, checked every cycle against a transaction-level line model.
module tb_cacheline_ctrl;

  logic        clock;
  logic        reset;
  logic        req_valid, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        req_ready, resp_valid, resp_hit, mem_valid, mem_write;
  logic [31:0] resp_rdata, mem_wdata;
  logic [7:0]  mem_addr;
`ifdef CACHELINE_CTRL_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cacheline_ctrl dut (
`ifdef CACHELINE_CTRL_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_hit   (resp_hit),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the line, the backing memory and the hit/miss tallies
  logic        m_valid, m_dirty;
  logic [7:0]  m_tag;
  logic [31:0] m_data;
  logic [31:0] backing [256];
  logic [15:0] m_hits, m_misses;

  // Expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_req_ready, exp_resp_valid, exp_resp_hit;
  logic        exp_mem_valid, exp_mem_write;
  logic [7:0]  exp_mem_addr;
  logic [31:0] exp_mem_wdata, exp_resp_rdata;

  // Observations for the literal checks
  logic [7:0]  last_wb_addr, last_rf_addr;
  logic [31:0] last_wb_data, last_rdata;
  logic        last_hit;
  int          mem_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model expectation
  always @(negedge clock) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_req_ready});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp_valid});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, exp_mem_valid});
      if (exp_mem_valid) begin
        chk("mem_write", {31'd0, mem_write}, {31'd0, exp_mem_write});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, exp_mem_addr});
        if (exp_mem_write) chk("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_resp_rdata);
        chk("resp_hit", {31'd0, resp_hit}, {31'd0, exp_resp_hit});
      end
    end
    if (mem_valid === 1'b1) mem_cycles++;
    if (mem_valid === 1'b1 && mem_ack === 1'b1) begin
      if (mem_write) begin
        last_wb_addr = mem_addr;
        last_wb_data = mem_wdata;
      end else begin
        last_rf_addr = mem_addr;
      end
    end
    if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
      last_rdata = resp_rdata;
      last_hit   = resp_hit;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_req_ready  = 1'b1;
    exp_resp_valid = 1'b0;
    exp_mem_valid  = 1'b0;
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_clear();
    m_valid  = 1'b0;
    m_dirty  = 1'b0;
    m_tag    = 8'h00;
    m_data   = 32'h0;
    m_hits   = 16'd0;
    m_misses = 16'd0;
  endtask

  // One memory transaction; ack arrives after ackw wait cycles
  task automatic mem_phase(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           input int ackw, input logic [31:0] rd);
    exp_req_ready  = 1'b0;
    exp_resp_valid = 1'b0;
    exp_mem_valid  = 1'b1;
    exp_mem_write  = wr;
    exp_mem_addr   = a;
    exp_mem_wdata  = d;
    for (int w = 0; w <= ackw; w++) begin
      mem_ack   = (w == ackw);
      mem_rdata = (w == ackw) ? rd : $urandom;
      step();
    end
    mem_ack = 1'b0;
  endtask

  // Full request: plan from the model, then drive and expect each phase.
  // abort_rf > 0 asserts reset after that many refill cycles instead of acking.
  task automatic run_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                         input int ackw, input int rspw, input int abort_rf);
    logic        hit, do_wb, do_rf;
    logic [7:0]  wb_a;
    logic [31:0] wb_d, rdata;
    hit   = m_valid && (m_tag == addr);
    do_wb = !hit && m_valid && m_dirty;
    do_rf = !hit && !wr;
    wb_a  = m_tag;
    wb_d  = m_data;
    if (hit) m_hits = sat16(m_hits); else m_misses = sat16(m_misses);

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    mem_ack = 1'($urandom_range(0, 1));
    step();
    // Requests offered while busy must be ignored
    req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
    req_addr = 8'($urandom); req_wdata = $urandom;
    mem_ack = 1'b0;

    if (do_wb) begin
      mem_phase(1'b1, wb_a, wb_d, ackw, 32'h0);
      backing[wb_a] = wb_d;
      m_dirty = 1'b0;
    end
    if (do_rf && abort_rf > 0) begin
      exp_req_ready = 1'b0; exp_resp_valid = 1'b0;
      exp_mem_valid = 1'b1; exp_mem_write = 1'b0; exp_mem_addr = addr;
      for (int w = 0; w < abort_rf; w++) step();
      reset = 1'b1;
      step();
      reset = 1'b0; req_valid = 1'b0;
      set_idle_exp();
      model_clear();
      return;
    end
    if (do_rf) begin
      mem_phase(1'b0, addr, 32'h0, ackw, backing[addr]);
      m_valid = 1'b1; m_dirty = 1'b0; m_tag = addr; m_data = backing[addr];
      rdata = m_data;
    end else if (hit && !wr) begin
      rdata = m_data;
    end else begin
      m_valid = 1'b1; m_dirty = 1'b1; m_tag = addr; m_data = wd;
      rdata = wd;
    end

    exp_req_ready  = 1'b0;
    exp_mem_valid  = 1'b0;
    exp_resp_valid = 1'b1;
    exp_resp_rdata = rdata;
    exp_resp_hit   = hit;
    for (int w = 0; w <= rspw; w++) begin
      resp_ready = (w == rspw);
      mem_ack    = 1'($urandom_range(0, 1));
      step();
    end
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    mem_ack    = 1'b0;
    set_idle_exp();
  endtask

  int mc0;

  initial begin
    for (int i = 0; i < 256; i++) backing[i] = $urandom;
    backing[8'h10] = 32'hDEADBEEF;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    req_wdata = 32'h0; resp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    model_clear();
    repeat (3) step();
    reset = 1'b0;
    set_idle_exp();
    chk_en = 1'b1;
    @(negedge clock);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_hit", {31'd0, resp_hit}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
`ifdef CACHELINE_CTRL_STATS_EN
    chk("rst_hit_count", {16'd0, hit_count}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
`endif
    step();

    // Cold load miss refilled after 3 wait cycles
    run_req(1'b0, 8'h10, 32'h0, 3, 0, 0);
    chk("cold_rf_addr", {24'd0, last_rf_addr}, 32'h10);
    chk("cold_rdata", last_rdata, 32'hDEADBEEF);
    chk("cold_hit", {31'd0, last_hit}, 32'd0);

    // Load hit: no memory traffic
    mc0 = mem_cycles;
    run_req(1'b0, 8'h10, 32'h0, 0, 0, 0);
    chk("hit_rdata", last_rdata, 32'hDEADBEEF);
    chk("hit_flag", {31'd0, last_hit}, 32'd1);
    chk("hit_no_mem", mem_cycles - mc0, 32'd0);

    // Store hit then conflicting load: writeback then refill
    run_req(1'b1, 8'h10, 32'h12345678, 1, 0, 0);
    run_req(1'b0, 8'h20, 32'h0, 2, 1, 0);
    chk("wb_addr", {24'd0, last_wb_addr}, 32'h10);
    chk("wb_data", last_wb_data, 32'h12345678);
    chk("rf_addr", {24'd0, last_rf_addr}, 32'h20);

    // Store miss on a clean line allocates without memory traffic
    mc0 = mem_cycles;
    run_req(1'b1, 8'h30, 32'hCAFEF00D, 0, 0, 0);
    chk("alloc_no_mem", mem_cycles - mc0, 32'd0);
    chk("alloc_hit", {31'd0, last_hit}, 32'd0);
    run_req(1'b0, 8'h30, 32'h0, 0, 0, 0);
    chk("alloc_rd", last_rdata, 32'hCAFEF00D);
    chk("alloc_rd_hit", {31'd0, last_hit}, 32'd1);

    // Zero-wait memory and response held back for 5 cycles
    run_req(1'b0, 8'h40, 32'h0, 0, 5, 0);

    // Reset in the middle of a refill
    run_req(1'b0, 8'h50, 32'h0, 0, 0, 2);
    @(negedge clock);
    chk("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
`ifdef CACHELINE_CTRL_STATS_EN
    chk("abort_hit_count", {16'd0, hit_count}, 32'd0);
    chk("abort_miss_count", {16'd0, miss_count}, 32'd0);
`endif
    step();
    run_req(1'b0, 8'h50, 32'h0, 1, 0, 0);
    chk("after_abort_miss", {31'd0, last_hit}, 32'd0);

    // Randomized traffic over a few conflicting addresses
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4) << 4);
      run_req(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 2), 0);
    end

`ifdef CACHELINE_CTRL_STATS_EN
    chk("hit_count", {16'd0, hit_count}, {16'd0, m_hits});
    chk("miss_count", {16'd0, miss_count}, {16'd0, m_misses});
`endif
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
